jk_bank: RTL

Parametrised bank of WIDTH JK flip-flops sharing one clock, with per-bit J/K inputs, selectable JK/D/T/hold interpretation, synchronous parallel load and change tracking. It is the multi-bit successor to the single JK-from-D flip-flop. It sits wherever the design needs a small block of control/state bits with set/clear/toggle semantics. A registered change flag and a saturating change-event counter let downstream logic and benches see activity without comparing q themselves.

---
 rtl/jk_bank.sv | 96 +++++++++
 1 files changed

// File: rtl/jk_bank.sv
// ---------------------------------------------------------------------------
// jk_bank
// Bank of WIDTH JK flip-flops on one clock. Each bit follows J/K, D, T or
// hold rules chosen by mode. A synchronous parallel load overrides the mode,
// and reset overrides everything. A registered change flag and a saturating
// change-event counter report activity on q.
//
// Ports
//   c     in   1      clock, rising edge
//   r     in   1      synchronous active-high reset
//   en    in   1      enable for mode-driven updates (ld ignores it)
//   mode  in   2      00 JK, 01 D (j is d), 10 T (j is t), 11 hold
//   ld    in   1      synchronous parallel load of d
//   d     in   WIDTH  parallel load data
//   j     in   WIDTH  J / D / T input, depending on mode
//   k     in   WIDTH  K input, used in JK mode only
//   q     out  WIDTH  registered state
//   qn    out  WIDTH  ~q
//   chg   out  1      q changed at the most recent edge
//   cnt   out  CNT_W  saturating count of edges at which q changed
// ---------------------------------------------------------------------------
module jk_bank #(
    parameter int                WIDTH   = 4,
    parameter int                CNT_W   = 3,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic              c,
    input  logic              r,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              ld,
    input  logic [WIDTH-1:0]  d,
    input  logic [WIDTH-1:0]  j,
    input  logic [WIDTH-1:0]  k,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic              chg,
    output logic [CNT_W-1:0]  cnt
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_D    = 2'b01;
    localparam logic [1:0] MODE_T    = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // The counter stops at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r_v;
        if (v == {CNT_W{1'b1}}) begin
            r_v = v;
        end else begin
            r_v = v + 1'b1;
        end
        return r_v;
    endfunction

    logic [WIDTH-1:0] q_nxt;
    logic             changed;

    always_comb begin
        q_nxt = q;
        if (ld) begin
            q_nxt = d;
        end else if (en) begin
            case (mode)
                // JK characteristic equation: set where J, keep where not K.
                MODE_JK:   q_nxt = (j & ~q) | (~k & q);
                MODE_D:    q_nxt = j;
                MODE_T:    q_nxt = q ^ j;
                MODE_HOLD: q_nxt = q;
                default:   q_nxt = q;
            endcase
        end
    end

    // Whole-vector comparison: rewriting the current value is not a change.
    assign changed = (q_nxt != q);

    // ---- state register stage ----
    always_ff @(posedge c) begin
        if (r) begin
            q   <= RST_VAL;
            chg <= 1'b0;
            cnt <= '0;
        end else begin
            q   <= q_nxt;
            chg <= changed;
            if (changed) begin
                cnt <= sat_inc(cnt);
            end
        end
    end

    assign qn = ~q;

endmodule
